// File: rtl/adc_ad7175_spi_slave_if.sv
// Signal bundle for the AD7175-style SPI register slave:
// SPI pins, the conversion-result input and the register-map outputs.
interface adc_ad7175_spi_slave_if;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic [1:0]  sample_channel;
    logic [15:0] adcmode_reg;
    logic [15:0] ifmode_reg;
    logic [3:0]  ch_en;
    logic        reg_wr_pulse;
    logic [5:0]  reg_wr_addr;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, sample_valid, sample_data, sample_channel,
        output spi_miso, spi_miso_oe, adcmode_reg, ifmode_reg, ch_en, reg_wr_pulse, reg_wr_addr
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, sample_valid, sample_data, sample_channel,
        input  spi_miso, spi_miso_oe, adcmode_reg, ifmode_reg, ch_en, reg_wr_pulse, reg_wr_addr
    );
endinterface

// File: rtl/adc_ad7175_spi_slave.sv
// SPI mode-3 slave emulating the AD7175 register map (comm byte, register
// reads/writes, DATA/STATUS readout with RDY indication, 64-ones serial reset).
module adc_ad7175_spi_slave #(
    parameter logic [15:0] ID_VALUE    = 16'h0CDE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  xclk,
    input  logic                  reset,
    adc_ad7175_spi_slave_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   sclk_prev;
    logic                   cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
        end else begin
            cs_sync[0]   <= bus.spi_cs_n;
            sclk_sync[0] <= bus.spi_sclk;
            mosi_sync[0] <= bus.spi_mosi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]   <= cs_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    state_t      state;
    logic [5:0]  bit_cnt, xfer_len, cur_addr;
    logic [14:0] shift_in;
    logic [31:0] shift_out;
    logic        rd_is_data;
    logic [15:0] adcmode_q, ifmode_q;
    logic [15:0] ch_q [4];
    logic [23:0] data_q, pend_data;
    logic [1:0]  data_ch, pend_ch;
    logic        rdy_n, pend_valid;
    logic [6:0]  ones_cnt;
    logic        miso_q, wr_pulse_q;
    logic [5:0]  wr_addr_q;

    logic [7:0]  cmd_byte, status;
    logic [15:0] wr_word;
    logic [31:0] dec_val;
    logic [5:0]  dec_len;
    logic        wr_ok, last_bit, merge_valid;
    logic [23:0] merge_data;
    logic [1:0]  merge_ch;

    assign cmd_byte    = {shift_in[6:0], mosi_s};
    assign wr_word     = {shift_in, mosi_s};
    assign status      = {rdy_n, 5'b0, data_ch};
    assign wr_ok       = (cur_addr == 6'h01) || (cur_addr == 6'h02) || (cur_addr[5:2] == 4'b0100);
    assign last_bit    = (bit_cnt == xfer_len - 6'd1);
    // A sample arriving in the very cycle a DATA read ends is treated as pending
    assign merge_valid = pend_valid | bus.sample_valid;
    assign merge_data  = bus.sample_valid ? bus.sample_data : pend_data;
    assign merge_ch    = bus.sample_valid ? bus.sample_channel : pend_ch;

    // Read value is left-aligned so the msb always leaves from bit 31
    always_comb begin
        dec_val = '0;
        dec_len = 6'd8;
        case (cmd_byte[5:0])
            6'h00: dec_val = {status, 24'h0};
            6'h01: begin dec_val = {adcmode_q, 16'h0}; dec_len = 6'd16; end
            6'h02: begin dec_val = {ifmode_q, 16'h0};  dec_len = 6'd16; end
            6'h04: begin
                if (ifmode_q[6]) begin
                    dec_val = {data_q, status};
                    dec_len = 6'd32;
                end else begin
                    dec_val = {data_q, 8'h0};
                    dec_len = 6'd24;
                end
            end
            6'h07: begin dec_val = {ID_VALUE, 16'h0}; dec_len = 6'd16; end
            6'h10, 6'h11, 6'h12, 6'h13: begin
                dec_val = {ch_q[cmd_byte[1:0]], 16'h0};
                dec_len = 6'd16;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            xfer_len   <= 6'd8;
            cur_addr   <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            rd_is_data <= 1'b0;
            adcmode_q  <= 16'h8000;
            ifmode_q   <= '0;
            ch_q[0]    <= 16'h8001;
            ch_q[1]    <= 16'h0001;
            ch_q[2]    <= 16'h0001;
            ch_q[3]    <= 16'h0001;
            data_q     <= '0;
            data_ch    <= '0;
            rdy_n      <= 1'b1;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_ch    <= '0;
            ones_cnt   <= '0;
            miso_q     <= 1'b1;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            if (bus.sample_valid) begin
                if (state == RD && rd_is_data) begin
                    pend_valid <= 1'b1;
                    pend_data  <= bus.sample_data;
                    pend_ch    <= bus.sample_channel;
                end else begin
                    data_q  <= bus.sample_data;
                    data_ch <= bus.sample_channel;
                    rdy_n   <= 1'b0;
                end
            end

            if (cs_s || (sclk_rise && !mosi_s)) ones_cnt <= '0;
            else if (sclk_rise)                 ones_cnt <= ones_cnt + 7'd1;

            if (cs_s) begin
                state   <= IDLE;
                miso_q  <= 1'b1;
                bit_cnt <= '0;
                if (state == RD && rd_is_data && merge_valid) begin
                    data_q     <= merge_data;
                    data_ch    <= merge_ch;
                    rdy_n      <= 1'b0;
                    pend_valid <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= '0;
                        miso_q  <= 1'b1;
                    end
                    CMD: begin
                        miso_q <= (bit_cnt == 6'd0) ? rdy_n : 1'b1;
                        if (sclk_rise) begin
                            shift_in <= {shift_in[13:0], mosi_s};
                            if (bit_cnt == 6'd7) begin
                                bit_cnt <= '0;
                                if (!cmd_byte[7]) begin
                                    xfer_len <= dec_len;
                                    cur_addr <= cmd_byte[5:0];
                                    if (cmd_byte[6]) begin
                                        state      <= RD;
                                        shift_out  <= dec_val;
                                        rd_is_data <= (cmd_byte[5:0] == 6'h04);
                                    end else begin
                                        state <= WR;
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    WR: begin
                        miso_q <= 1'b1;
                        if (sclk_rise) begin
                            shift_in <= {shift_in[13:0], mosi_s};
                            if (last_bit) begin
                                state   <= CMD;
                                bit_cnt <= '0;
                                if (wr_ok) begin
                                    case (cur_addr)
                                        6'h01:   adcmode_q <= wr_word;
                                        6'h02:   ifmode_q  <= wr_word;
                                        default: ch_q[cur_addr[1:0]] <= wr_word;
                                    endcase
                                    wr_pulse_q <= 1'b1;
                                    wr_addr_q  <= cur_addr;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    RD: begin
                        if (sclk_fall) begin
                            miso_q    <= shift_out[31];
                            shift_out <= {shift_out[30:0], 1'b0};
                        end
                        // Leave RD only after the master has sampled the last bit
                        if (sclk_rise) begin
                            if (last_bit) begin
                                state   <= CMD;
                                bit_cnt <= '0;
                                if (rd_is_data) begin
                                    if (merge_valid) begin
                                        data_q     <= merge_data;
                                        data_ch    <= merge_ch;
                                        rdy_n      <= 1'b0;
                                        pend_valid <= 1'b0;
                                    end else begin
                                        rdy_n <= 1'b1;
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (sclk_rise && mosi_s && ones_cnt == 7'd63) begin
                    adcmode_q  <= 16'h8000;
                    ifmode_q   <= '0;
                    ch_q[0]    <= 16'h8001;
                    ch_q[1]    <= 16'h0001;
                    ch_q[2]    <= 16'h0001;
                    ch_q[3]    <= 16'h0001;
                    rdy_n      <= 1'b1;
                    pend_valid <= 1'b0;
                    state      <= CMD;
                    bit_cnt    <= '0;
                    ones_cnt   <= '0;
                    wr_pulse_q <= 1'b0;
                end
            end
        end
    end

    assign bus.spi_miso     = miso_q;
    assign bus.spi_miso_oe  = ~cs_s;
    assign bus.adcmode_reg  = adcmode_q;
    assign bus.ifmode_reg   = ifmode_q;
    assign bus.ch_en        = {ch_q[3][15], ch_q[2][15], ch_q[1][15], ch_q[0][15]};
    assign bus.reg_wr_pulse = wr_pulse_q;
    assign bus.reg_wr_addr  = wr_addr_q;
endmodule

// File: tb/tb_adc_ad7175_spi_slave.sv
// Self-checking bench for adc_ad7175_spi_slave: directed register-map scenarios
// plus randomized transactions checked against a register-map reference model.
module tb_adc_ad7175_spi_slave;
    localparam logic [15:0] ID = 16'h0CDE;

    logic xclk  = 1'b0;
    logic reset = 1'b1;

    adc_ad7175_spi_slave_if bus ();

    adc_ad7175_spi_slave #(.ID_VALUE(ID), .SYNC_STAGES(2)) dut (
        .xclk  (xclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 xclk = ~xclk;

    int tests = 0;
    int fails = 0;

    int         pulse_cnt = 0;
    logic [5:0] last_wr_addr = '0;
    always @(negedge xclk) begin
        if (!reset && bus.reg_wr_pulse === 1'b1) begin
            pulse_cnt++;
            last_wr_addr = bus.reg_wr_addr;
        end
    end

    // Reference model: the register map as plain variables
    logic [15:0] m_adcmode, m_ifmode;
    logic [15:0] m_ch [4];
    logic [23:0] m_data, m_pend_data;
    logic [1:0]  m_chan, m_pend_chan;
    logic        m_rdy_n, m_pend;

    function automatic void model_writable_reset();
        m_adcmode = 16'h8000;
        m_ifmode  = 16'h0000;
        m_ch[0]   = 16'h8001;
        m_ch[1]   = 16'h0001;
        m_ch[2]   = 16'h0001;
        m_ch[3]   = 16'h0001;
        m_rdy_n   = 1'b1;
        m_pend    = 1'b0;
    endfunction

    function automatic void model_full_reset();
        model_writable_reset();
        m_data = '0;
        m_chan = '0;
    endfunction

    function automatic bit m_is_writable(input logic [5:0] a);
        return (a == 6'h01) || (a == 6'h02) || (a >= 6'h10 && a <= 6'h13);
    endfunction

    function automatic int m_len(input logic [5:0] a);
        if (a == 6'h01 || a == 6'h02 || a == 6'h07 || (a >= 6'h10 && a <= 6'h13)) return 16;
        if (a == 6'h04) return m_ifmode[6] ? 32 : 24;
        return 8;
    endfunction

    function automatic logic [31:0] m_val(input logic [5:0] a);
        logic [7:0] st;
        st = {m_rdy_n, 5'b00000, m_chan};
        if (a == 6'h00) return {24'h0, st};
        if (a == 6'h01) return {16'h0, m_adcmode};
        if (a == 6'h02) return {16'h0, m_ifmode};
        if (a == 6'h04) return m_ifmode[6] ? {m_data, st} : {8'h0, m_data};
        if (a == 6'h07) return {16'h0, ID};
        if (a >= 6'h10 && a <= 6'h13) return {16'h0, m_ch[a[1:0]]};
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_adcmode"}, {16'h0, bus.adcmode_reg}, {16'h0, m_adcmode});
        chk({tag, "_ifmode"},  {16'h0, bus.ifmode_reg},  {16'h0, m_ifmode});
        chk({tag, "_ch_en"},   {28'h0, bus.ch_en},
            {28'h0, m_ch[3][15], m_ch[2][15], m_ch[1][15], m_ch[0][15]});
    endtask

    task automatic xfer_bit(input logic mo, output logic mi);
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = mo;
        #50;
        mi = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        #50;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], d);
    endtask

    task automatic cs_low(input string tag);
        bus.spi_cs_n = 1'b0;
        #100;
        chk({tag, "_rdy"}, {31'h0, bus.spi_miso}, {31'h0, m_rdy_n});
        chk({tag, "_oe"},  {31'h0, bus.spi_miso_oe}, 32'h1);
    endtask

    task automatic cs_high();
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        #100;
    endtask

    // Loads a sample; the model applies it directly unless a DATA read is running
    task automatic load_sample(input logic [23:0] d, input logic [1:0] c, input bit in_data_read);
        @(negedge xclk);
        bus.sample_data    = d;
        bus.sample_channel = c;
        bus.sample_valid   = 1'b1;
        @(negedge xclk);
        bus.sample_valid   = 1'b0;
        if (in_data_read) begin
            m_pend      = 1'b1;
            m_pend_data = d;
            m_pend_chan = c;
        end else begin
            m_data  = d;
            m_chan  = c;
            m_rdy_n = 1'b0;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] v, input string tag);
        int   n;
        int   p0;
        bit   w;
        logic d;
        n  = m_len(a);
        p0 = pulse_cnt;
        w  = m_is_writable(a);
        cs_low(tag);
        send_byte({2'b00, a});
        for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], d);
        #100;
        if (w) begin
            if (a == 6'h01)      m_adcmode = v[15:0];
            else if (a == 6'h02) m_ifmode  = v[15:0];
            else                 m_ch[a[1:0]] = v[15:0];
        end
        chk({tag, "_pulses"}, pulse_cnt - p0, w ? 1 : 0);
        if (w) chk({tag, "_wr_addr"}, {26'h0, last_wr_addr}, {26'h0, a});
        chk_regs(tag);
        cs_high();
    endtask

    task automatic do_read(input logic [5:0] a, input int inject_at, input logic [23:0] inj_d,
                           input logic [1:0] inj_c, input string tag, output logic [31:0] got);
        int          n;
        int          p0;
        logic [31:0] exp;
        logic        b;
        n   = m_len(a);
        p0  = pulse_cnt;
        cs_low(tag);
        exp = m_val(a);
        got = '0;
        send_byte({2'b01, a});
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) load_sample(inj_d, inj_c, a == 6'h04);
            xfer_bit(1'b0, b);
            got = {got[30:0], b};
        end
        chk({tag, "_value"}, got, exp);
        if (a == 6'h04) begin
            if (m_pend) begin
                m_data  = m_pend_data;
                m_chan  = m_pend_chan;
                m_rdy_n = 1'b0;
                m_pend  = 1'b0;
            end else begin
                m_rdy_n = 1'b1;
            end
        end
        #100;
        chk({tag, "_rdy_after"}, {31'h0, bus.spi_miso}, {31'h0, m_rdy_n});
        chk({tag, "_no_pulse"}, pulse_cnt - p0, 0);
        cs_high();
    endtask

    logic [5:0]  wr_addrs [6]  = '{6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h13};
    logic [5:0]  ro_addrs [5]  = '{6'h00, 6'h04, 6'h05, 6'h07, 6'h3E};
    logic [5:0]  rd_addrs [11] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h07, 6'h10,
                                   6'h11, 6'h12, 6'h13, 6'h3F, 6'h20};

    initial begin
        logic [31:0] got;
        logic        d;
        bus.spi_cs_n       = 1'b1;
        bus.spi_sclk       = 1'b1;
        bus.spi_mosi       = 1'b0;
        bus.sample_valid   = 1'b0;
        bus.sample_data    = '0;
        bus.sample_channel = '0;
        model_full_reset();
        #2;
        #20;
        chk("rst_miso",     {31'h0, bus.spi_miso},     32'h1);
        chk("rst_oe",       {31'h0, bus.spi_miso_oe},  32'h0);
        chk("rst_pulse",    {31'h0, bus.reg_wr_pulse}, 32'h0);
        chk("rst_wr_addr",  {26'h0, bus.reg_wr_addr},  32'h0);
        chk_regs("rst");
        chk("rst_ch_en_const", {28'h0, bus.ch_en}, 32'h1);
        reset = 1'b0;
        #100;

        // ID register readback
        do_read(6'h07, -1, '0, '0, "id_read", got);
        chk("id_const", got, 32'h0000_0CDE);

        // ADCMODE write, then an aborted second write
        do_write(6'h01, 32'h8C00, "adcmode_wr");
        chk("adcmode_const", {16'h0, bus.adcmode_reg}, 32'h8C00);
        begin
            int p0;
            p0 = pulse_cnt;
            cs_low("abort_wr");
            send_byte(8'h01);
            send_byte(8'h12);
            cs_high();
            chk("abort_wr_adcmode", {16'h0, bus.adcmode_reg}, 32'h8C00);
            chk("abort_wr_pulses", pulse_cnt - p0, 0);
        end

        // DATA_STAT read: 32 bits = data + status
        do_write(6'h02, 32'h0040, "ifmode_ds");
        load_sample(24'hABCDEF, 2'd2, 1'b0);
        do_read(6'h04, -1, '0, '0, "data_stat", got);
        chk("data_stat_const", got, 32'hABCDEF02);
        do_read(6'h00, -1, '0, '0, "status_after", got);
        chk("status_after_const", got, 32'h0000_0082);

        // Sample arriving mid DATA read is held until the read ends
        do_write(6'h02, 32'h0000, "ifmode_clr");
        load_sample(24'h111111, 2'd3, 1'b0);
        do_read(6'h04, 8, 24'h123456, 2'd1, "pend_cur", got);
        chk("pend_cur_const", got, 32'h0011_1111);
        do_read(6'h00, -1, '0, '0, "pend_status", got);
        chk("pend_status_const", got, 32'h0000_0001);
        do_read(6'h04, -1, '0, '0, "pend_next", got);
        chk("pend_next_const", got, 32'h0012_3456);

        // Randomized transactions against the model
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: do_write(wr_addrs[$urandom_range(0, 5)], {16'h0, 16'($urandom)}, "rnd_wr");
                1: do_write(ro_addrs[$urandom_range(0, 4)], {16'h0, 16'($urandom)}, "rnd_ro_wr");
                2: load_sample(24'($urandom), 2'($urandom), 1'b0);
                default: do_read(rd_addrs[$urandom_range(0, 10)], -1, '0, '0, "rnd_rd", got);
            endcase
        end

        // 64-ones serial reset
        do_write(6'h12, 32'h8001, "ch2_wr");
        load_sample(24'h0F0F0F, 2'd1, 1'b0);
        cs_low("ones");
        for (int i = 0; i < 64; i++) xfer_bit(1'b1, d);
        model_writable_reset();
        #100;
        chk_regs("ones");
        chk("ones_ch_en_const", {28'h0, bus.ch_en}, 32'h1);
        chk("ones_rdy", {31'h0, bus.spi_miso}, 32'h1);
        send_byte(8'h47);
        got = '0;
        for (int i = 0; i < 16; i++) begin
            xfer_bit(1'b0, d);
            got = {got[30:0], d};
        end
        chk("ones_id", got, {16'h0, ID});
        cs_high();

        // Reset asserted in the middle of a read
        do_write(6'h01, 32'h1234, "pre_rst_wr");
        load_sample(24'h777777, 2'd3, 1'b0);
        cs_low("mid_rst");
        send_byte(8'h47);
        for (int i = 0; i < 5; i++) xfer_bit(1'b0, d);
        reset = 1'b1;
        #1;
        model_full_reset();
        chk("mid_rst_miso",    {31'h0, bus.spi_miso},     32'h1);
        chk("mid_rst_oe",      {31'h0, bus.spi_miso_oe},  32'h0);
        chk("mid_rst_pulse",   {31'h0, bus.reg_wr_pulse}, 32'h0);
        chk("mid_rst_wr_addr", {26'h0, bus.reg_wr_addr},  32'h0);
        chk_regs("mid_rst");
        #20;
        reset = 1'b0;
        cs_high();
        do_read(6'h00, -1, '0, '0, "post_rst_status", got);
        chk("post_rst_status_const", got, 32'h0000_0080);
        do_read(6'h04, -1, '0, '0, "post_rst_data", got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
